friscv_mem_arbiter: RTL

- Two-master, one-slave arbiter for the core's data-memory handshake bus (en/wr/addr/wdata/strb/rdata/ready).
- Shares a single data memory port between the processing unit's load/store master (m0) and a second requester (m1, e.g. debug/loader/DMA).
- Sits between those masters and the memory router.
- Round-robin fairness, one outstanding transfer at a time, optional watchdog timeout that forces completion.

---
 rtl/friscv_mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/friscv_mem_arbiter.sv
// Two-master round-robin arbiter for the data-memory handshake bus.
// One transfer in flight at a time; an optional watchdog forces completion after TIMEOUT cycles.
module friscv_mem_arbiter #(
    parameter int unsigned ADDRW   = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic                m0_en,
    input  logic                m0_wr,
    input  logic [ADDRW-1:0]    m0_addr,
    input  logic [XLEN-1:0]     m0_wdata,
    input  logic [XLEN/8-1:0]   m0_strb,
    output logic [XLEN-1:0]     m0_rdata,
    output logic                m0_ready,
    input  logic                m1_en,
    input  logic                m1_wr,
    input  logic [ADDRW-1:0]    m1_addr,
    input  logic [XLEN-1:0]     m1_wdata,
    input  logic [XLEN/8-1:0]   m1_strb,
    output logic [XLEN-1:0]     m1_rdata,
    output logic                m1_ready,
    output logic                slv_en,
    output logic                slv_wr,
    output logic [ADDRW-1:0]    slv_addr,
    output logic [XLEN-1:0]     slv_wdata,
    output logic [XLEN/8-1:0]   slv_strb,
    input  logic [XLEN-1:0]     slv_rdata,
    input  logic                slv_ready,
    output logic [1:0]          grant,
    output logic                timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;       // 0: m0 favoured on contention, 1: m1 favoured
    logic   wd_limit;
    logic   own_en;
    logic   oth_en;
    logic   fire;
    logic   done;

    // Next state, pointer update and combinational routing of the granted master
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        slv_en    = 1'b0;
        slv_wr    = 1'b0;
        slv_addr  = '0;
        slv_wdata = '0;
        slv_strb  = '0;
        m0_ready  = 1'b0;
        m0_rdata  = '0;
        m1_ready  = 1'b0;
        m1_rdata  = '0;
        grant     = 2'b00;
        timeout   = 1'b0;
        own_en    = 1'b0;
        oth_en    = 1'b0;
        fire      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_en && m1_en) begin
                    state_d = ptr_q ? GNT1 : GNT0;
                end else if (m0_en) begin
                    state_d = GNT0;
                end else if (m1_en) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (state_q == GNT0) begin
                    own_en    = m0_en;
                    oth_en    = m1_en;
                    slv_wr    = m0_wr;
                    slv_addr  = m0_addr;
                    slv_wdata = m0_wdata;
                    slv_strb  = m0_strb;
                    grant     = 2'b01;
                end else begin
                    own_en    = m1_en;
                    oth_en    = m0_en;
                    slv_wr    = m1_wr;
                    slv_addr  = m1_addr;
                    slv_wdata = m1_wdata;
                    slv_strb  = m1_strb;
                    grant     = 2'b10;
                end

                // A real reply at the limit cycle wins over the watchdog
                fire    = own_en & wd_limit & ~slv_ready;
                done    = (own_en & slv_ready) | fire;
                slv_en  = own_en & ~fire;
                timeout = fire;

                if (state_q == GNT0) begin
                    m0_ready = done;
                    m0_rdata = fire ? '0 : slv_rdata;
                end else begin
                    m1_ready = done;
                    m1_rdata = fire ? '0 : slv_rdata;
                end

                if (!own_en) begin
                    state_d = IDLE;
                end else if (done) begin
                    ptr_d   = (state_q == GNT0);
                    state_d = oth_en ? ((state_q == GNT0) ? GNT1 : GNT0) : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    if (TIMEOUT > 0) begin : g_wdog
        localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

        logic [CNTW-1:0] cnt_q, cnt_d;

        // Counts granted cycles of the current transfer; any state change restarts it
        always_comb begin
            cnt_d = '0;
            if (state_q != IDLE && state_d == state_q) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end

        always_ff @(posedge aclk) begin
            if (srst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign wd_limit = (cnt_q == CNTW'(TIMEOUT - 1));
    end else begin : g_no_wdog
        assign wd_limit = 1'b0;
    end

endmodule
